mult_cell_arbiter: RTL and testbench
====================================

# mult_cell_arbiter

- Time-shares one pipelined 32-bit multiply cell among up to four requesters.
- The cell returns the low 32 bits of `src1*src2`, `CELL_LATENCY` clocks after its inputs are sampled.
- The block does round-robin arbitration, drives the cell operands, and tags in-flight operations with the requester ID.
- It holds each result in a per-requester response register until that requester accepts it. It sits between custom-instruction/accelerator masters and the shared multiplier in the SoC fabric.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 1..4.
- `CELL_LATENCY`, default 1: clock edges from cell operand sampling to valid `mul_cell_result`, legal range 1..3.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- `req_valid`  in  NUM_REQ  per-requester operation request.
- `req_ready`  out  NUM_REQ  grant; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `req_a`  in  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i].
- `req_b`  in  32*NUM_REQ  operand B, same packing as `req_a`.
- `resp_valid`  out  NUM_REQ  result available for requester i.
- `resp_ready`  in  NUM_REQ  requester i accepts its result.
- `resp_data`  out  32*NUM_REQ  registered result, same packing as `req_a`.
- `mul_src1`  out  32  operand A to the cell.
- `mul_src2`  out  32  operand B to the cell.
- `mul_cell_result`  in  32  low 32 bits of the cell product.
- `busy`  out  1  high while any slot is not IDLE.

## Operation
- **Per-requester slot FSM:** states IDLE, INFLIGHT, DONE.
  - IDLE -> INFLIGHT on a request handshake.
  - INFLIGHT -> DONE when the tagged result is captured.
  - DONE -> IDLE on `resp_valid[i] & resp_ready[i]`.
- **Eligibility:** requester i is eligible iff `req_valid[i]` is high and slot i is IDLE (registered state).
- **Grant:**
  - At most one grant per cycle.
  - `req_ready` is combinational from eligibility and the round-robin pointer. It is one-hot or zero.
  - `req_ready` does not depend on `resp_ready`.
- **Round-robin pointer:**
  - Search starts at requester `ptr`, ascending with wrap.
  - On a grant to requester g, `ptr` becomes `(g+1) mod NUM_REQ`. Otherwise `ptr` holds.
  - Reset value of `ptr` is 0.
- **Operand drive:** `mul_src1`/`mul_src2` are combinational.
  - In a grant cycle they carry the granted requester's operands.
  - Otherwise they are 0, which avoids needless toggling.
- **Tag pipeline:**
  - `CELL_LATENCY` stages of {valid, id[1:0]}, shifted every clock.
  - Stage 0 is loaded with {grant, granted id}.
  - When the last stage is valid, `mul_cell_result` is written into `resp_data[id]` and slot id goes to DONE.
- **Arithmetic:** the result is the low 32 bits of the product, identical for signed and unsigned operands. No overflow flag; wrap-around is silent.
- **Response register:**
  - `resp_data[i]` is stable while `resp_valid[i]` is high.
  - `resp_data[i]` holds its last value after the result is accepted.
  - `resp_valid[i]` = (slot i == DONE).
- **Simultaneous events:**
  - Capture for requester j and response accept for requester k≠j in the same cycle are independent.
  - A requester cannot be re-granted in the cycle its response is accepted; its slot is not yet IDLE.
- **Back-pressure:**
  - A requester stalling `resp_ready` blocks only itself.
  - Other requesters continue to be granted every cycle.
- **Reset, asynchronous:**
  - All slots go to IDLE, tag pipeline valid bits clear, `ptr`=0, `resp_data`=0.
  - In-flight operations are discarded. Cell output after reset is ignored because no tags are valid.
- **Reset values:** `req_ready`=0, `resp_valid`=0, `resp_data`=0, `mul_src1`=`mul_src2`=0, `busy`=0.

## Timing
- **Request and result capture:**
  - The request handshake occurs in cycle c; the cell samples operands at the end of cycle c.
  - The result is valid on `mul_cell_result` in cycle c+`CELL_LATENCY`, captured at the end of that cycle.
  - `resp_valid` rises in cycle c+`CELL_LATENCY`+1. With default latency the request-to-`resp_valid` latency is 2 cycles.
- **Response and re-grant:** response accepted in cycle d -> slot IDLE in cycle d+1 -> `req_ready` can be high in d+1.
- **Per-requester throughput:** one operation per `CELL_LATENCY`+2 cycles with `resp_ready` held high.
- **Aggregate throughput:** one grant per cycle.
- **`busy`:** registered OR of slot states; falls in the cycle after the last accept.

## Test plan
- **Single operation:** `req_valid[0]`=1, a=3, b=5 in cycle c -> `req_ready[0]`=1 in c; `resp_valid[0]`=1, `resp_data[0]`=15 in c+2 (`CELL_LATENCY`=1).
- **Wrap-around:**
  - a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000001.
  - a=0x00010000, b=0x00010000 -> 0x00000000.
  - a=0x12345678, b=0x9ABCDEF0 -> 0x242D2080.
- **Contention:** both requesters valid from cycle 0 after reset -> grant req0 in cycle 0 and req1 in cycle 1. With both held valid and `resp_ready`=1, grants alternate; no requester is granted twice in a row while the other is eligible.
- **Back-pressure:**
  - Hold `resp_ready[1]`=0 for 10 cycles after `resp_valid[1]` rises -> `resp_data[1]` stable, `req_ready[1]`=0.
  - Requester 0 completes every 3 cycles throughout.
  - Release -> req1 is re-granted one cycle after its accept.
- **Reset mid-flight:** assert `reset` in the cycle after a grant -> no `resp_valid` ever for that operation; `busy`=0 and `ptr`=0 after release. A fresh request returns the correct product.
- **Latency sweep:** `CELL_LATENCY`=3, `NUM_REQ`=4, back-to-back grants to ids 0,1,2,3 with distinct operands -> each result routed to the matching `resp_data` slot, 4 cycles after its grant.

Source files
------------

// File: rtl/mult_cell_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_cell_arbiter
// Purpose  : Round-robin time-sharing of one pipelined 32-bit multiply cell
//            among up to four requesters. Each requester owns a slot
//            (IDLE -> INFLIGHT -> DONE) and a response register that holds
//            its result until the requester accepts it.
// Ports    : clk, reset (async, active-high)
//            req_valid/req_ready/req_a/req_b       request side, 32b packed
//            resp_valid/resp_ready/resp_data       response side, 32b packed
//            mul_src1/mul_src2/mul_cell_result     multiply cell interface
//            busy                                  any slot not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module mult_cell_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int CELL_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [32*NUM_REQ-1:0] resp_data,
    output logic [31:0]           mul_src1,
    output logic [31:0]           mul_src2,
    input  logic [31:0]           mul_cell_result,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_INFLIGHT = 2'd1,
        S_DONE     = 2'd2
    } slot_state_t;

    slot_state_t             r_state [NUM_REQ];
    logic [1:0]              r_ptr;
    logic [CELL_LATENCY-1:0] r_tag_vld;
    logic [1:0]              r_tag_id [CELL_LATENCY];

    logic       w_gnt_vld;
    logic [1:0] w_gnt_id;
    logic [1:0] w_next_ptr;
    logic       w_cap_vld;
    logic [1:0] w_cap_id;
    int         w_idx;

    // Round-robin search: visit requesters ptr, ptr+1, ... with wrap and
    // take the first eligible one (valid request and slot IDLE).
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 2'd0;
        w_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_gnt_vld && (i == w_idx) && req_valid[i] &&
                    (r_state[i] == S_IDLE)) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_id  = 2'(i);
                end
            end
        end
    end

    assign w_next_ptr = ((int'(w_gnt_id) + 1) >= NUM_REQ) ? 2'd0 : (w_gnt_id + 2'd1);

    // Operands are forced to zero outside grant cycles so the cell inputs
    // do not toggle with unrelated requester traffic.
    always_comb begin
        req_ready = '0;
        mul_src1  = 32'd0;
        mul_src2  = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_vld && (w_gnt_id == 2'(i))) begin
                req_ready[i] = 1'b1;
                mul_src1     = req_a[32*i +: 32];
                mul_src2     = req_b[32*i +: 32];
            end
        end
    end

    // The tag travels alongside the operation through the cell; the last
    // stage lines up with the cycle in which the cell result is valid.
    assign w_cap_vld = r_tag_vld[CELL_LATENCY-1];
    assign w_cap_id  = r_tag_id[CELL_LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_vld <= '0;
            for (int s = 0; s < CELL_LATENCY; s++) begin
                r_tag_id[s] <= 2'd0;
            end
        end else begin
            r_tag_vld[0] <= w_gnt_vld;
            r_tag_id[0]  <= w_gnt_id;
            for (int s = 1; s < CELL_LATENCY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= 2'd0;
            resp_data <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_state[i] <= S_IDLE;
            end
        end else begin
            if (w_gnt_vld) begin
                r_ptr <= w_next_ptr;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                case (r_state[i])
                    S_IDLE: begin
                        if (req_valid[i] && req_ready[i]) begin
                            r_state[i] <= S_INFLIGHT;
                        end
                    end
                    S_INFLIGHT: begin
                        if (w_cap_vld && (w_cap_id == 2'(i))) begin
                            r_state[i]          <= S_DONE;
                            resp_data[32*i +: 32] <= mul_cell_result;
                        end
                    end
                    S_DONE: begin
                        if (resp_ready[i]) begin
                            r_state[i] <= S_IDLE;
                        end
                    end
                    default: r_state[i] <= S_IDLE;
                endcase
            end
        end
    end

    // Decoded directly from the slot registers, so both outputs are glitch
    // free and busy drops in the cycle after the final accept.
    always_comb begin
        resp_valid = '0;
        busy       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = (r_state[i] == S_DONE);
            if (r_state[i] != S_IDLE) begin
                busy = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_cell_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_cell_arbiter
// Purpose  : Self-checking bench. Instance A uses the default configuration
//            (2 requesters, latency 1); instance B uses 4 requesters with
//            latency 3. Each instance drives a behavioural multiply cell.
//            A scoreboard records every request handshake and checks the
//            routed result and its arrival cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_cell_arbiter;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Instance A signals
    logic [1:0]  a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
    logic [63:0] a_req_a, a_req_b, a_resp_data;
    logic [31:0] a_src1, a_src2, a_cell;
    logic        a_busy;

    // Instance B signals
    logic [3:0]   b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [127:0] b_req_a, b_req_b, b_resp_data;
    logic [31:0]  b_src1, b_src2, b_cell, b_p0, b_p1;
    logic         b_busy;

    exp_t sb_a[$];
    exp_t sb_b[$];
    logic [1:0] a_prev;
    logic [3:0] b_prev;

    int          n;
    int          last_g0;
    logic [31:0] held;

    mult_cell_arbiter u_dut_a (
        .clk             (clk),
        .reset           (rst),
        .req_valid       (a_req_valid),
        .req_ready       (a_req_ready),
        .req_a           (a_req_a),
        .req_b           (a_req_b),
        .resp_valid      (a_resp_valid),
        .resp_ready      (a_resp_ready),
        .resp_data       (a_resp_data),
        .mul_src1        (a_src1),
        .mul_src2        (a_src2),
        .mul_cell_result (a_cell),
        .busy            (a_busy)
    );

    mult_cell_arbiter #(.NUM_REQ(4), .CELL_LATENCY(3)) u_dut_b (
        .clk             (clk),
        .reset           (rst),
        .req_valid       (b_req_valid),
        .req_ready       (b_req_ready),
        .req_a           (b_req_a),
        .req_b           (b_req_b),
        .resp_valid      (b_resp_valid),
        .resp_ready      (b_resp_ready),
        .resp_data       (b_resp_data),
        .mul_src1        (b_src1),
        .mul_src2        (b_src2),
        .mul_cell_result (b_cell),
        .busy            (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiply cells
    always @(posedge clk) a_cell <= a_src1 * a_src2;
    always @(posedge clk) begin
        b_p0   <= b_src1 * b_src2;
        b_p1   <= b_p0;
        b_cell <= b_p1;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        int k;
        if (rst) begin
            sb_a.delete();
            a_prev = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (a_resp_valid[i]) begin
                    k = -1;
                    foreach (sb_a[j]) if (k < 0 && sb_a[j].id == i) k = j;
                    if (k < 0) begin
                        check_val("a_spurious_resp", {31'd0, a_resp_valid[i]}, 32'd0);
                    end else begin
                        check_val("a_resp_data", a_resp_data[32*i +: 32], sb_a[k].data);
                        if (!a_prev[i]) check_val("a_resp_cycle", cyc, sb_a[k].due);
                        if (a_resp_ready[i]) sb_a.delete(k);
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (a_req_valid[i] && a_req_ready[i])
                    sb_a.push_back('{id: i, data: a_req_a[32*i +: 32] * a_req_b[32*i +: 32], due: cyc + 2});
            end
            a_prev = a_resp_valid;
        end
    end

    always @(negedge clk) begin
        int k;
        if (rst) begin
            sb_b.delete();
            b_prev = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (b_resp_valid[i]) begin
                    k = -1;
                    foreach (sb_b[j]) if (k < 0 && sb_b[j].id == i) k = j;
                    if (k < 0) begin
                        check_val("b_spurious_resp", {31'd0, b_resp_valid[i]}, 32'd0);
                    end else begin
                        check_val("b_resp_data", b_resp_data[32*i +: 32], sb_b[k].data);
                        if (!b_prev[i]) check_val("b_resp_cycle", cyc, sb_b[k].due);
                        if (b_resp_ready[i]) sb_b.delete(k);
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (b_req_valid[i] && b_req_ready[i])
                    sb_b.push_back('{id: i, data: b_req_a[32*i +: 32] * b_req_b[32*i +: 32], due: cyc + 4});
            end
            b_prev = b_resp_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation on instance A: wait for grant, then for the response,
    // and compare against a fixed expected product.
    task automatic op_a(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input string tag);
        int t;
        a_req_a[32*id +: 32] = a;
        a_req_b[32*id +: 32] = b;
        a_req_valid[id]      = 1'b1;
        t = 0;
        @(negedge clk);
        while (!a_req_ready[id] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check_val({tag, "_grant_timeout"}, {31'd0, a_req_ready[id]}, 32'd1);
        tick();
        a_req_valid[id] = 1'b0;
        t = 0;
        @(negedge clk);
        while (!a_resp_valid[id] && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_val(tag, a_resp_data[32*id +: 32], expv);
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((a_busy || b_busy) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_val("drain_busy", {30'd0, a_busy, b_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        a_req_valid  = '0;
        a_req_a      = '0;
        a_req_b      = '0;
        a_resp_ready = 2'b11;
        b_req_valid  = '0;
        b_req_a      = '0;
        b_req_b      = '0;
        b_resp_ready = 4'hF;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check_val("rst_req_ready", {30'd0, a_req_ready}, 32'd0);
        check_val("rst_resp_valid", {30'd0, a_resp_valid}, 32'd0);
        check_val("rst_resp_data0", a_resp_data[31:0], 32'd0);
        check_val("rst_resp_data1", a_resp_data[63:32], 32'd0);
        check_val("rst_src1", a_src1, 32'd0);
        check_val("rst_src2", a_src2, 32'd0);
        check_val("rst_busy", {31'd0, a_busy}, 32'd0);
        check_val("rst_b_resp_valid", {28'd0, b_resp_valid}, 32'd0);
        check_val("rst_b_busy", {31'd0, b_busy}, 32'd0);
        tick();
        rst = 1'b0;

        // Single operation with grant / latency / busy timing
        tick();
        a_req_valid[0] = 1'b1;
        a_req_a[31:0]  = 32'd3;
        a_req_b[31:0]  = 32'd5;
        @(negedge clk);
        check_val("single_ready", {30'd0, a_req_ready}, 32'd1);
        check_val("single_src1", a_src1, 32'd3);
        check_val("single_src2", a_src2, 32'd5);
        tick();
        a_req_valid[0] = 1'b0;
        @(negedge clk);
        check_val("single_c1_valid", {30'd0, a_resp_valid}, 32'd0);
        check_val("single_c1_busy", {31'd0, a_busy}, 32'd1);
        check_val("idle_src1", a_src1, 32'd0);
        @(negedge clk);
        check_val("single_c2_valid", {30'd0, a_resp_valid}, 32'd1);
        check_val("single_c2_data", a_resp_data[31:0], 32'd15);
        @(negedge clk);
        check_val("single_c3_busy", {31'd0, a_busy}, 32'd0);
        check_val("hold_data", a_resp_data[31:0], 32'd15);

        // Wrap-around products
        op_a(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "wrap_ffff");
        op_a(1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "wrap_2p32");
        op_a(0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, "wrap_mixed");
        drain();

        // Contention straight out of reset: 01, 10, 00 repeating
        tick();
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        a_req_valid = 2'b11;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check_val("contention_ready", {30'd0, a_req_ready},
                      (k % 3 == 0) ? 32'd1 : ((k % 3 == 1) ? 32'd2 : 32'd0));
            tick();
            a_req_a = {$urandom, $urandom};
            a_req_b = {$urandom, $urandom};
        end

        // Back-pressure on requester 1
        a_resp_ready[1] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!a_resp_valid[1] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_val("bp_resp1_rise", {31'd0, a_resp_valid[1]}, 32'd1);
        held    = a_resp_data[63:32];
        last_g0 = -1;
        for (int k = 0; k < 10; k++) begin
            check_val("bp_data1_stable", a_resp_data[63:32], held);
            check_val("bp_ready1_low", {31'd0, a_req_ready[1]}, 32'd0);
            if (a_req_ready[0]) begin
                if (last_g0 >= 0) check_val("bp_req0_period", cyc - last_g0, 32'd3);
                last_g0 = cyc;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        a_resp_ready[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("bp_regrant1", {30'd0, a_req_ready}, 32'd2);
        tick();
        a_req_valid = 2'b00;
        drain();

        // Reset in the cycle after a grant; ptr would be 1 without reset
        tick();
        a_req_valid   = 2'b01;
        a_req_a[31:0] = 32'd7;
        a_req_b[31:0] = 32'd9;
        @(negedge clk);
        check_val("mid_grant", {30'd0, a_req_ready}, 32'd1);
        tick();
        a_req_valid = 2'b00;
        rst         = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("mid_no_resp", {30'd0, a_resp_valid}, 32'd0);
            check_val("mid_busy", {31'd0, a_busy}, 32'd0);
        end
        tick();
        a_req_a     = {32'd11, 32'd6};
        a_req_b     = {32'd13, 32'd7};
        a_req_valid = 2'b11;
        @(negedge clk);
        check_val("post_rst_ptr0", {30'd0, a_req_ready}, 32'd1);
        tick();
        @(negedge clk);
        check_val("post_rst_next", {30'd0, a_req_ready}, 32'd2);
        tick();
        a_req_valid = 2'b00;
        @(negedge clk);
        check_val("fresh_data0", a_resp_data[31:0], 32'd42);
        @(negedge clk);
        check_val("fresh_data1", a_resp_data[63:32], 32'd143);
        drain();

        // Latency sweep on instance B: grants 0,1,2,3 back to back
        tick();
        b_req_a     = {32'h0000_0011, 32'h0000_0101, 32'h1000_0003, 32'hDEAD_BEEF};
        b_req_b     = {32'h0000_0013, 32'h0000_0202, 32'h0000_0010, 32'h0000_0002};
        b_req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("sweep_grant", {28'd0, b_req_ready}, 32'd1 << k);
            tick();
            b_req_valid[k] = 1'b0;
        end
        drain();
        check_val("sweep_data0", b_resp_data[31:0],   32'hBD5B_7DDE);
        check_val("sweep_data1", b_resp_data[63:32],  32'h0000_0030);
        check_val("sweep_data2", b_resp_data[95:64],  32'h0002_0402);
        check_val("sweep_data3", b_resp_data[127:96], 32'h0000_0143);

        check_val("sb_a_empty", sb_a.size(), 32'd0);
        check_val("sb_b_empty", sb_b.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
